// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared flit layouts, response codes and FSM states for the write bridge
package sn_pkg;

  localparam int FLIT_W    = 82;
  localparam int AW_BITS_W = 76;
  localparam int W_BITS_W  = 77;
  localparam int B_BITS_W  = 17;
  localparam int B_FLIT_W  = 20;
  localparam int B_PAD_W   = B_FLIT_W - B_BITS_W;

  localparam int AW_LEN_LSB = 47;
  localparam int AW_LEN_W   = 8;
  localparam int W_LAST_BIT = 72;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  user;
    logic [3:0]  qos;
    logic [2:0]  prot;
    logic [3:0]  cache;
    logic        lock;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [3:0]  region;
    logic [31:0] addr;
    logic [10:0] id;
  } aw_bits_t;

  typedef struct packed {
    logic [3:0]  user;
    logic        last;
    logic [7:0]  strb;
    logic [63:0] data;
  } w_bits_t;

  typedef struct packed {
    logic [3:0]  user;
    logic [1:0]  resp;
    logic [10:0] id;
  } b_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_ISSUE,
    ST_W_DATA,
    ST_B_WAIT,
    ST_B_SEND
  } state_t;

  // A framing error turns an OKAY from the slave into SLVERR; real slave errors win.
  function automatic logic [1:0] merge_resp(input logic err, input logic [1:0] resp);
    return (err && (resp == RESP_OKAY)) ? RESP_SLVERR : resp;
  endfunction

endpackage

// File: rtl/sn_write_bridge.sv
// rtl/sn_write_bridge.sv - NoC-to-AXI write bridge, one outstanding burst at a time
module sn_write_bridge
  import sn_pkg::*;
#(
  parameter int NODE_W    = 2,
  parameter int MAX_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [FLIT_W-1:0]    aw_payload,
  input  logic [NODE_W-1:0]    aw_srcid,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 w_head,
  input  logic                 w_tail,
  input  logic [FLIT_W-1:0]    w_payload,
  input  logic [NODE_W-1:0]    w_srcid,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [B_FLIT_W-1:0]  b_payload,
  output logic [NODE_W-1:0]    b_tgtid,
  output logic                 m_aw_valid,
  input  logic                 m_aw_ready,
  output logic [AW_BITS_W-1:0] m_aw_bits,
  output logic                 m_w_valid,
  input  logic                 m_w_ready,
  output logic [W_BITS_W-1:0]  m_w_bits,
  input  logic                 m_b_valid,
  output logic                 m_b_ready,
  input  logic [B_BITS_W-1:0]  m_b_bits
);

  state_t                state, state_nx;
  aw_bits_t              aw_q;
  b_bits_t               b_q;
  b_bits_t               b_in;
  w_bits_t               w_in;
  w_bits_t               w_out;
  logic [NODE_W-1:0]     src_q;
  logic [MAX_LEN_W-1:0]  len_q;
  logic [MAX_LEN_W-1:0]  beat_cnt;
  logic                  err_q;
  logic                  src_match;
  logic                  beat_last;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_in_fire;
  logic                  unused_bits;

  assign w_in      = w_bits_t'(w_payload[W_BITS_W-1:0]);
  assign b_in      = b_bits_t'(m_b_bits);
  assign src_match = (w_srcid == src_q);
  assign beat_last = (beat_cnt == len_q);
  assign aw_fire   = aw_valid && aw_ready;
  assign w_fire    = m_w_valid && m_w_ready;
  assign b_in_fire = m_b_valid && m_b_ready;

  assign m_aw_bits = aw_q;
  assign m_w_bits  = w_out;
  assign b_payload = {{B_PAD_W{1'b0}}, b_q};
  assign b_tgtid   = src_q;

  // Flit bits outside the AXI layouts and the sender's LAST are deliberately ignored.
  assign unused_bits = ^{aw_payload[FLIT_W-1:AW_BITS_W], w_payload[FLIT_W-1:W_BITS_W],
                         w_payload[W_LAST_BIT]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state: the captured LEN, not w_tail, decides where the burst ends
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (aw_valid)             state_nx = ST_AW_ISSUE;
      ST_AW_ISSUE: if (m_aw_ready)           state_nx = ST_W_DATA;
      ST_W_DATA:   if (w_fire && beat_last)  state_nx = ST_B_WAIT;
      ST_B_WAIT:   if (m_b_valid)            state_nx = ST_B_SEND;
      ST_B_SEND:   if (b_ready)              state_nx = ST_IDLE;
      default:                               state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs; W flits from other senders stay back-pressured
  always_comb begin
    aw_ready   = 1'b0;
    m_aw_valid = 1'b0;
    w_ready    = 1'b0;
    m_w_valid  = 1'b0;
    m_b_ready  = 1'b0;
    b_valid    = 1'b0;
    case (state)
      ST_IDLE:     aw_ready   = 1'b1;
      ST_AW_ISSUE: m_aw_valid = 1'b1;
      ST_W_DATA: begin
        w_ready   = m_w_ready && src_match;
        m_w_valid = w_valid && src_match;
      end
      ST_B_WAIT:   m_b_ready  = 1'b1;
      ST_B_SEND:   b_valid    = 1'b1;
      default: ;
    endcase
  end

  // W data path is zero latency; LAST is regenerated from the beat count
  always_comb begin
    w_out      = w_in;
    w_out.last = beat_last;
  end

  // Capture the AW request and its requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_q  <= '0;
      src_q <= '0;
      len_q <= '0;
    end else if (aw_fire) begin
      aw_q  <= aw_bits_t'(aw_payload[AW_BITS_W-1:0]);
      src_q <= aw_srcid;
      len_q <= MAX_LEN_W'(aw_payload[AW_LEN_LSB +: AW_LEN_W]);
    end
  end

  // Beat counter and head/tail framing check on every forwarded beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (aw_fire) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (w_fire) begin
      beat_cnt <= beat_cnt + MAX_LEN_W'(1);
      if ((w_head != (beat_cnt == '0)) || (w_tail != beat_last)) err_q <= 1'b1;
    end
  end

  // Capture the slave response, folding in any framing error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q <= '0;
    end else if (b_in_fire) begin
      b_q.id   <= b_in.id;
      b_q.resp <= merge_resp(err_q, b_in.resp);
      b_q.user <= b_in.user;
    end
  end

endmodule

// File: tb/tb_sn_write_bridge.sv
// tb/tb_sn_write_bridge.sv - randomized scoreboard bench for sn_write_bridge
module tb_sn_write_bridge;

  localparam int NODE_W    = 2;
  localparam int MAX_LEN_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               aw_valid, aw_ready;
  logic [81:0]        aw_payload;
  logic [NODE_W-1:0]  aw_srcid;
  logic               w_valid, w_ready, w_head, w_tail;
  logic [81:0]        w_payload;
  logic [NODE_W-1:0]  w_srcid;
  logic               b_valid, b_ready;
  logic [19:0]        b_payload;
  logic [NODE_W-1:0]  b_tgtid;
  logic               m_aw_valid, m_aw_ready;
  logic [75:0]        m_aw_bits;
  logic               m_w_valid, m_w_ready;
  logic [76:0]        m_w_bits;
  logic               m_b_valid, m_b_ready;
  logic [16:0]        m_b_bits;

  sn_write_bridge #(.NODE_W(NODE_W), .MAX_LEN_W(MAX_LEN_W)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload), .aw_srcid(aw_srcid),
    .w_valid(w_valid), .w_ready(w_ready), .w_head(w_head), .w_tail(w_tail),
    .w_payload(w_payload), .w_srcid(w_srcid),
    .b_valid(b_valid), .b_ready(b_ready), .b_payload(b_payload), .b_tgtid(b_tgtid),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits(m_aw_bits),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits(m_w_bits),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits(m_b_bits)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [75:0]        exp_aw[$];
  logic [76:0]        exp_w[$];
  logic [NODE_W+19:0] exp_b[$];
  logic [16:0]        slave_b_q[$];

  logic [NODE_W-1:0]  cur_src = '0;
  bit wphase = 0, last_seen = 0, mb_done = 0, b_stalled = 0;
  logic [NODE_W+19:0] b_prev;
  int b_stall_cnt = 0;
  int aw_rdy_mode = 0, w_rdy_mode = 0, b_rand = 0, b_hold = 0, b_delay = 0;
  int t_aw = 0, t_maw = 0, t_mw = 0, t_mb = 0, t_b = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares whatever the DUT presents against queued expectations
  initial begin
    logic [76:0]        ew;
    logic [NODE_W+19:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_stalled = 0;
      end else begin
        if (w_valid && w_ready && !wphase) chk("w_ready_outside_burst", 1, 0);
        if (wphase && w_valid && (w_srcid == cur_src)) chk("w_ready_mirror", w_ready, m_w_ready);
        if (m_w_valid && m_w_ready) begin
          if (exp_w.size() == 0) chk("m_w_unexpected", 1, 0);
          else begin
            ew = exp_w.pop_front();
            chk("m_w_bits", m_w_bits, ew);
            t_mw = cyc;
            if (ew[72]) begin wphase = 0; last_seen = 1; end
          end
        end
        if (m_aw_valid && m_aw_ready) begin
          if (exp_aw.size() == 0) chk("m_aw_unexpected", 1, 0);
          else chk("m_aw_bits", m_aw_bits, exp_aw.pop_front());
          wphase = 1;
          t_maw = cyc;
        end
        if (m_b_valid && m_b_ready) begin mb_done = 1; t_mb = cyc; end
        if (b_valid) begin
          if (b_stalled) begin
            chk("b_stable", {b_tgtid, b_payload}, b_prev);
            chk("aw_ready_during_b", aw_ready, 0);
          end
          if (b_ready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else begin
              eb = exp_b.pop_front();
              chk("b_flit", {b_tgtid, b_payload}, eb);
            end
            t_b = cyc;
            b_stalled = 0;
          end else begin
            b_stall_cnt++;
            b_stalled = 1;
            b_prev = {b_tgtid, b_payload};
          end
        end else begin
          if (b_stalled) chk("b_valid_held", 0, 1);
          b_stalled = 0;
        end
      end
    end
  end

  // AXI slave model: configurable ready patterns, B response after the last beat
  initial begin
    bit pend;
    int bcnt;
    pend = 0; bcnt = 0;
    m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_bits = '0;
    forever begin
      @(posedge clk); #1;
      m_aw_ready = (aw_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (w_rdy_mode)
        0:       m_w_ready = 1'b1;
        1:       m_w_ready = ~m_w_ready;
        default: m_w_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst) begin
        m_b_valid = 0; pend = 0; last_seen = 0; mb_done = 0;
      end else begin
        if (mb_done) begin m_b_valid = 0; mb_done = 0; end
        if (last_seen) begin last_seen = 0; pend = 1; bcnt = b_delay; end
        if (pend && !m_b_valid) begin
          if (bcnt == 0) begin
            pend = 0;
            m_b_valid = 1;
            if (slave_b_q.size() == 0) chk("slave_b_queue", 1, 0);
            else m_b_bits = slave_b_q.pop_front();
          end else bcnt--;
        end
      end
    end
  end

  // NoC B sink: optional fixed stall, otherwise always or randomly ready
  initial begin
    b_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (b_valid && b_hold > 0) begin b_ready = 0; b_hold--; end
      else b_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // One complete write: model computes AW, per-beat W and final B expectations up front
  task automatic do_txn(input int len, input logic [NODE_W-1:0] src, input int head_at,
                        input int tail_at, input logic [1:0] sresp, input int wrong_pct,
                        input int gap_pct);
    logic [95:0] r;
    logic [81:0] awp;
    logic [81:0] wp[$];
    bit          hd[$];
    bit          tl[$];
    bit          err;
    logic [10:0] bid;
    logic [3:0]  bus;
    logic [1:0]  eresp;
    int          n;
    r = {$urandom(), $urandom(), $urandom()};
    awp = r[81:0];
    awp[54:47] = 8'(len);
    exp_aw.push_back(awp[75:0]);
    err = 0;
    for (int i = 0; i <= len; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      wp.push_back(r[81:0]);
      hd.push_back(i == head_at);
      tl.push_back(i == tail_at);
      if (((i == head_at) != (i == 0)) || ((i == tail_at) != (i == len))) err = 1;
      exp_w.push_back({r[76:73], (i == len) ? 1'b1 : 1'b0, r[71:0]});
    end
    bid = 11'($urandom());
    bus = 4'($urandom());
    eresp = (err && sresp == 2'b00) ? 2'b10 : sresp;
    slave_b_q.push_back({bus, sresp, bid});
    exp_b.push_back({src, 3'b000, bus, eresp, bid});
    cur_src = src;
    fork
      begin
        int k;
        @(posedge clk); #1;
        aw_valid = 1; aw_payload = awp; aw_srcid = src;
        k = 0;
        forever begin
          @(negedge clk);
          if (aw_ready) break;
          k++;
          if (k > 2000) begin chk("aw_timeout", 1, 0); break; end
        end
        t_aw = cyc;
        @(posedge clk); #1;
        aw_valid = 0;
      end
      begin
        for (int i = 0; i <= len; i++) begin
          if (int'($urandom_range(0, 99)) < wrong_pct) begin
            @(posedge clk); #1;
            w_valid = 1; w_srcid = src + 1'b1;
            w_payload = {$urandom(), $urandom(), 18'($urandom())};
            w_head = 1'($urandom()); w_tail = 1'($urandom());
            repeat (3) begin
              @(negedge clk);
              chk("wrong_src_w_ready", w_ready, 0);
              chk("wrong_src_m_w_valid", m_w_valid, 0);
            end
          end
          if (int'($urandom_range(0, 99)) < gap_pct) begin
            @(posedge clk); #1;
            w_valid = 0;
          end
          @(posedge clk); #1;
          w_valid = 1; w_srcid = src; w_payload = wp[i]; w_head = hd[i]; w_tail = tl[i];
          begin
            int k;
            k = 0;
            forever begin
              @(negedge clk);
              if (w_ready) break;
              k++;
              if (k > 2000) begin chk("w_timeout", 1, 0); break; end
            end
          end
        end
        @(posedge clk); #1;
        w_valid = 0;
      end
    join
    n = 0;
    while (exp_b.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 5000) begin
        chk("b_timeout", 1, 0);
        exp_b.delete(); slave_b_q.delete();
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] r;
    logic [81:0] awp;
    int          len, ha, ta;
    logic [1:0]  sr;
    aw_valid = 0; aw_payload = '0; aw_srcid = '0;
    w_valid = 0; w_head = 0; w_tail = 0; w_payload = '0; w_srcid = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_m_aw_valid", m_aw_valid, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_m_w_valid", m_w_valid, 0);
    chk("rst_m_b_ready", m_b_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_payload", b_payload, 0);
    chk("rst_b_tgtid", b_tgtid, 0);
    chk("rst_m_aw_bits", m_aw_bits, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("aw_ready_after_release", aw_ready, 1);

    // Single-beat minimum turnaround
    do_txn(0, 2'd2, 0, 0, 2'b00, 0, 0);
    chk("t_m_aw", t_maw - t_aw, 1);
    chk("t_m_w", t_mw - t_aw, 2);
    chk("t_m_b", t_mb - t_aw, 3);
    chk("t_b_flit", t_b - t_aw, 4);
    @(negedge clk);
    chk("aw_ready_back", aw_ready, 1);
    chk("t_aw_ready", cyc - t_aw, 5);

    // Toggling slave W ready
    w_rdy_mode = 1;
    do_txn(3, 2'd2, 0, 3, 2'b00, 0, 0);
    w_rdy_mode = 0;

    // Early tail gets SLVERR although the slave says OKAY
    do_txn(3, 2'd2, 0, 2, 2'b00, 0, 0);

    // Flits from a foreign sender are held off
    do_txn(1, 2'd2, 0, 1, 2'b00, 100, 0);

    // B flit held by the NoC for five cycles
    b_hold = 5; b_stall_cnt = 0;
    do_txn(2, 2'd1, 0, 2, 2'b01, 0, 0);
    chk("b_stall_cycles", b_stall_cnt, 5);

    // Reset during beat 1 of a 4-beat burst
    cur_src = 2'd2;
    r = {$urandom(), $urandom(), $urandom()};
    awp = r[81:0];
    awp[54:47] = 8'd3;
    exp_aw.push_back(awp[75:0]);
    r = {$urandom(), $urandom(), $urandom()};
    exp_w.push_back({r[76:73], 1'b0, r[71:0]});
    @(posedge clk); #1;
    aw_valid = 1; aw_payload = awp; aw_srcid = 2'd2;
    w_valid = 1; w_srcid = 2'd2; w_payload = r[81:0]; w_head = 1; w_tail = 0;
    @(negedge clk);
    chk("rst_test_aw_ready", aw_ready, 1);
    @(posedge clk); #1;
    aw_valid = 0;
    begin
      int k;
      k = 0;
      forever begin
        @(negedge clk);
        if (w_ready) break;
        k++;
        if (k > 50) begin chk("rst_test_w_timeout", 1, 0); break; end
      end
    end
    @(posedge clk); #1;
    w_payload = {$urandom(), $urandom(), 18'($urandom())}; w_head = 0; w_tail = 0;
    #1 rst = 1;
    #1;
    chk("async_aw_ready", aw_ready, 1);
    chk("async_m_aw_valid", m_aw_valid, 0);
    chk("async_w_ready", w_ready, 0);
    chk("async_m_w_valid", m_w_valid, 0);
    chk("async_m_b_ready", m_b_ready, 0);
    chk("async_b_valid", b_valid, 0);
    chk("async_b_payload", b_payload, 0);
    chk("async_b_tgtid", b_tgtid, 0);
    chk("async_m_aw_bits", m_aw_bits, 0);
    chk("rst_beat0_forwarded", exp_w.size(), 0);
    w_valid = 0;
    exp_w.delete(); exp_b.delete(); exp_aw.delete(); slave_b_q.delete();
    wphase = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_valid) chk("b_after_reset", 1, 0);
    end
    chk("no_b_after_reset", b_valid, 0);
    do_txn(1, 2'd3, 0, 1, 2'b00, 0, 0);

    // Maximum length burst
    do_txn(255, 2'd0, 0, 255, 2'b00, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      aw_rdy_mode = 1;
      w_rdy_mode  = $urandom_range(0, 2);
      b_rand      = 1;
      b_delay     = $urandom_range(0, 3);
      len = (int'($urandom_range(0, 99)) < 70) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 20));
      ha  = (int'($urandom_range(0, 99)) < 15) ? int'($urandom_range(0, len + 1)) : 0;
      ta  = (int'($urandom_range(0, 99)) < 15) ? int'($urandom_range(0, len + 1)) : len;
      sr  = (int'($urandom_range(0, 99)) < 60) ? 2'b00 : 2'($urandom());
      do_txn(len, NODE_W'($urandom()), ha, ta, sr, 10, 20);
    end

    repeat (5) @(posedge clk);
    chk("queues_drained", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn_write_bridge.md
SN_WRITE_BRIDGE -- requirements
Module: sn_write_bridge

Interface
REQ-001 Parameter NODE_W, default 2, is the node-ID width used for srcid and tgtid.
REQ-002 Parameter MAX_LEN_W, default 8, is the AWLEN and beat-counter width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 aw_valid/aw_ready  input/output  1/1  AW request flit handshake from NoC.
REQ-006 aw_payload  input  82  AW flit; [75:0] = AW bits (ID[10:0], ADDR[42:11], REGION[46:43], LEN[54:47], SIZE[57:55], BURST[59:58], LOCK[60], CACHE[64:61], PROT[67:65], QOS[71:68], USER[75:72]); [81:76] ignored.
REQ-007 aw_srcid  input  NODE_W  requesting node ID.
REQ-008 w_valid/w_ready  input/output  1/1  W data flit handshake from NoC.
REQ-009 w_head, w_tail  input  1 each  first/last flit markers of a write burst.
REQ-010 w_payload  input  82  W flit; DATA[63:0], STRB[71:64], LAST[72], USER[76:73]; [81:77] ignored.
REQ-011 w_srcid  input  NODE_W  sender node ID of W flit.
REQ-012 b_valid/b_ready  output/input  1/1  B response flit handshake to NoC.
REQ-013 b_payload  output  20  ID[10:0], RESP[12:11], USER[16:13], [19:17]=0.
REQ-014 b_tgtid  output  NODE_W  destination node, equals captured aw_srcid.
REQ-015 m_aw_valid/m_aw_ready  output/input  1/1  AXI AW handshake to local slave.
REQ-016 m_aw_bits  output  76  AXI AW fields, same layout as aw_payload[75:0].
REQ-017 m_w_valid/m_w_ready  output/input  1/1  AXI W handshake.
REQ-018 m_w_bits  output  77  DATA/STRB/LAST/USER, same layout as w_payload[76:0] except LAST generated internally.
REQ-019 m_b_valid/m_b_ready  input/output  1/1  AXI B handshake.
REQ-020 m_b_bits  input  17  ID[10:0], RESP[12:11], USER[16:13].

Function
REQ-021 FSM states IDLE, AW_ISSUE, W_DATA, B_WAIT, B_SEND; one outstanding write at a time.
REQ-022 aw_ready = (state==IDLE); on aw_valid&&aw_ready capture aw_payload[75:0], aw_srcid, LEN; clear beat_cnt and err; go AW_ISSUE.
REQ-023 AW_ISSUE: m_aw_valid=1 from registered AW bits; on m_aw_ready go W_DATA; m_aw_valid never drops before handshake.
REQ-024 W_DATA: w_ready = m_w_ready && (w_srcid==captured srcid); m_w_valid = w_valid && (w_srcid==captured srcid); data/strb/user pass combinationally (zero latency).
REQ-025 Generated m_w_bits LAST = (beat_cnt==LEN); beat_cnt increments per m_w handshake, saturates never (width MAX_LEN_W, LEN+1 beats, LEN=255 gives 256 beats).
REQ-026 err sets if on any accepted beat w_head != (beat_cnt==0) or w_tail != (beat_cnt==LEN); LEN governs burst end regardless of w_tail.
REQ-027 Handshake of beat LEN moves W_DATA->B_WAIT.
REQ-028 B_WAIT: m_b_ready=1; on m_b_valid capture m_b_bits; RESP forced to 2'b10 (SLVERR) if err and slave RESP==2'b00, else slave RESP kept; go B_SEND.
REQ-029 B_SEND: b_valid=1 registered, b_payload/b_tgtid stable until b_ready; on handshake go IDLE; aw_ready high the following cycle.
REQ-030 W flits arriving in IDLE/AW_ISSUE/B_* are back-pressured (w_ready=0), never dropped.
REQ-031 Minimum turnaround for LEN=0 with always-ready slave/NoC: aw accept cycle N, m_aw N+1, m_w N+2, m_b N+3, b flit N+4, aw_ready N+5.

Reset
REQ-032 On rst: state=IDLE, beat_cnt=0, err=0, captured registers 0; aw_ready=1 after release, all other valid/ready outputs 0, b_payload=0, b_tgtid=0.
REQ-033 Reset mid-transaction abandons it silently; no B flit is emitted for it.

Structure
REQ-034 Shared package sn_pkg holds field offsets/widths for AW/W/B payloads, packed typedefs aw_bits_t/w_bits_t/b_bits_t, RESP encodings, FSM state enum.
REQ-035 Single module, no sub-module; the beat counter is inline.

Verification
REQ-036 LEN=0, srcid=2, ready everywhere: one AW+one W(head,tail) -> m_w LAST=1, b flit RESP=00, b_tgtid=2, timing per REQ-031.
REQ-037 LEN=3, m_w_ready toggling 1/0: 4 beats forwarded in order, LAST only on 4th, w_ready mirrors m_w_ready.
REQ-038 LEN=3, w_tail on beat 2 -> 4 beats still forwarded, slave RESP=00, b flit RESP=10.
REQ-039 W flit with w_srcid=1 while captured srcid=2 -> w_ready=0 until matching flit; no m_w_valid.
REQ-040 rst asserted during W_DATA beat 1 -> all outputs at reset values same cycle (async), no b flit, next AW accepted normally.
REQ-041 b_ready held 0 for 5 cycles -> b_valid and b_payload stable, aw_ready=0 throughout.
